// File: rtl/jk_div_pkg.sv
// Shared constants and divisor helpers for the programmable JK clock divider.
package jk_div_pkg;

  localparam int unsigned CNT_W_DEF = 8;

  // A divisor of zero has no meaningful period, so it is promoted to one.
  function automatic logic [31:0] sanitize_div(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

  function automatic logic [31:0] half_point(input logic [31:0] n);
    return (n + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/jk_prog_clk_divider_if.sv
// Control/status bundle of the programmable divider: master drives, slave is the divider.
interface jk_prog_clk_divider_if
  import jk_div_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic             en;
  logic             load;
  logic [CNT_W-1:0] div_in;
  logic [CNT_W-1:0] cnt_o;
  logic             tick;
  logic             div_out;
  logic             pend;

  modport master (
    output en, load, div_in,
    input  cnt_o, tick, div_out, pend
  );

  modport slave (
    input  en, load, div_in,
    output cnt_o, tick, div_out, pend
  );

endinterface

// File: rtl/jk_ff_sync.sv
// Single JK flip-flop with synchronous active-high clear and clock enable.
module jk_ff_sync (
  input  logic clk,
  input  logic clr,
  input  logic ce,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= 1'b0;
    end else if (ce) begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_prog_clk_divider.sv
// Runtime-programmable divide-by-N tick generator with a JK-held near-50% divided output.
module jk_prog_clk_divider
  import jk_div_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned DEF_DIV = 3
) (
  input  logic                  clk,
  input  logic                  clr,
  jk_prog_clk_divider_if.slave  bus
);

  localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] p_q;
  logic             pend_q;
  logic [CNT_W-1:0] cnt_q;
  logic             tick_q;
  logic             div_q;

  logic             wrap;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] half;
  logic             k_in;

  always_comb begin
    wrap    = bus.en && (cnt_q == n_q - 1'b1);
    cnt_nxt = wrap ? '0 : cnt_q + 1'b1;
    half    = CNT_W'(half_point(32'(n_q)));
    // Falling edge only mid-period; a wrap lands on 0, which is never H.
    k_in    = (cnt_nxt == half) && (n_q != CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      n_q    <= DEF_N;
      p_q    <= '0;
      pend_q <= 1'b0;
      cnt_q  <= DEF_N - 1'b1;
      tick_q <= 1'b0;
    end else begin
      tick_q <= wrap;
      if (bus.en) begin
        cnt_q <= cnt_nxt;
      end
      if (wrap && pend_q) begin
        n_q    <= p_q;
        pend_q <= 1'b0;
      end
      // A load on a wrap edge re-arms pend after the old value is applied.
      if (bus.load) begin
        p_q    <= CNT_W'(sanitize_div(32'(bus.div_in)));
        pend_q <= 1'b1;
      end
    end
  end

  jk_ff_sync u_div_ff (
    .clk (clk),
    .clr (clr),
    .ce  (bus.en),
    .j   (wrap),
    .k   (k_in),
    .q   (div_q)
  );

  assign bus.cnt_o   = cnt_q;
  assign bus.tick    = tick_q;
  assign bus.div_out = div_q;
  assign bus.pend    = pend_q;

endmodule
